// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame geometry, FSM states, frame check helper.
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_DATA_BITS  = 8;
   localparam int unsigned PS2_CNT_W      = $clog2(PS2_DATA_BITS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   // Good frame: stop bit high and odd parity across data plus parity bit.
   function automatic logic frame_ok(input logic [PS2_DATA_BITS-1:0] bits_v,
                                     input logic                     parity_v,
                                     input logic                     stop_v);
      return stop_v & (^{bits_v, parity_v});
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines plus rising-edge detect on the clock line.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic rise_c,
   output logic data_sync
);

   logic clk_s1;
   logic clk_s2;
   logic clk_s3;
   logic data_s1;
   logic data_s2;

   // Equal-depth chains keep clock/data alignment; reset high so release is edge-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         clk_s3  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         clk_s3  <= clk_s2;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   assign rise_c    = clk_s2 & ~clk_s3;
   assign data_sync = data_s2;

endmodule

// File: rtl/ps2_rx_interface.sv
// PS/2 device-to-host frame decoder: deserializes 11-bit frames and strobes good bytes.
module ps2_rx_interface
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   output logic [PS2_DATA_BITS-1:0] data,
   output logic                     valid
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_e               state_q;
   ps2_state_e               state_d;
   logic                     rise_c;
   logic                     data_sync;
   logic [PS2_DATA_BITS-1:0] shreg_q;
   logic [PS2_CNT_W-1:0]     bit_cnt_q;
   logic                     parity_q;
   logic [TO_W-1:0]          to_cnt_q;
   logic                     timeout_c;
   logic                     last_bit_c;
   logic                     start_c;
   logic                     shift_c;
   logic                     par_c;
   logic                     check_c;
   logic                     frame_good_c;

   ps2_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rise_c    (rise_c),
      .data_sync (data_sync)
   );

   assign timeout_c    = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
   assign last_bit_c   = (bit_cnt_q == PS2_CNT_W'(PS2_DATA_BITS - 1));
   assign frame_good_c = check_c & frame_ok(shreg_q, parity_q, data_sync);

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: advance on each sampled rise, abort to IDLE on a stalled frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rise_c && !data_sync) state_d = DATA;
         end
         DATA: begin
            if (rise_c) begin
               if (last_bit_c) state_d = PARITY;
            end else if (timeout_c) begin
               state_d = IDLE;
            end
         end
         PARITY: begin
            if (rise_c)         state_d = STOP;
            else if (timeout_c) state_d = IDLE;
         end
         STOP: begin
            if (rise_c || timeout_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-state datapath strobes, all qualified by a sampled rise.
   always_comb begin
      start_c = 1'b0;
      shift_c = 1'b0;
      par_c   = 1'b0;
      check_c = 1'b0;
      case (state_q)
         IDLE:    start_c = rise_c & ~data_sync;
         DATA:    shift_c = rise_c;
         PARITY:  par_c   = rise_c;
         STOP:    check_c = rise_c;
         default: ;
      endcase
   end

   // Shift register, bit counter and parity capture; LSB arrives first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
      end else begin
         if (start_c) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
         end else if (shift_c) begin
            shreg_q   <= {data_sync, shreg_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + PS2_CNT_W'(1);
         end
         if (par_c) parity_q <= data_sync;
      end
   end

   // Cycles since the last rise while mid-frame; saturates at the timeout value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
      end else if (state_q == IDLE || rise_c) begin
         to_cnt_q <= '0;
      end else if (!timeout_c) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end

   // Output byte holds until the next good frame; valid is a one-cycle strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= frame_good_c;
         if (frame_good_c) data <= shreg_q;
      end
   end

endmodule

// File: tb/tb_ps2_rx_interface.sv
// Directed bench for ps2_rx_interface: reset, good/bad frames, timeout, reset mid-frame.
module tb_ps2_rx_interface;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data;
   logic       valid;

   int         n_cmp     = 0;
   int         n_err     = 0;
   int         pulse_cnt = 0;
   int         dbl_cnt   = 0;
   int         base;
   logic       valid_prev = 1'b0;
   logic [7:0] rx_log [$];

   logic [7:0] good_b [5] = '{8'h45, 8'h35, 8'h55, 8'hAA, 8'hFF};
   logic       good_p [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1};

   ps2_rx_interface dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data     (data),
      .valid    (valid)
   );

   always #10 clk = ~clk;

   // Log every valid pulse and count any that last two cycles.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         pulse_cnt++;
         rx_log.push_back(data);
         if (valid_prev === 1'b1) dbl_cnt++;
      end
      valid_prev = valid;
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkn(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One PS/2 bit: data changes with the falling edge, 20 ns low then 20 ns high.
   task automatic send_bit(input logic b);
      @(negedge clk);
      ps2_clk  = 1'b0;
      ps2_data = b;
      @(negedge clk);
      ps2_clk  = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   // Called right at the stop-bit rise: valid must be low two cycles later,
   // high with the byte at E2 (third negedge), and low again one cycle after.
   task automatic expect_frame(input logic [7:0] exp, input string tag);
      @(negedge clk);
      @(negedge clk);
      check1({tag, "_valid_early"}, valid, 1'b0);
      @(negedge clk);
      check1({tag, "_valid_e2"}, valid, 1'b1);
      check8({tag, "_data_e2"}, data, exp);
      @(negedge clk);
      check1({tag, "_valid_e3"}, valid, 1'b0);
   endtask

   task automatic expect_none(input logic [7:0] prev, input string tag);
      repeat (4) @(negedge clk);
      check1({tag, "_valid"}, valid, 1'b0);
      check8({tag, "_data_hold"}, data, prev);
   endtask

   initial begin
      reset    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;

      // Reset held while the lines toggle: outputs stay cleared.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ps2_clk  = ~ps2_clk;
         ps2_data = i[1];
         #1;
         check8($sformatf("rst_data_%0d", i), data, 8'h00);
         check1($sformatf("rst_valid_%0d", i), valid, 1'b0);
      end
      @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checkn("post_rst_pulses", pulse_cnt, 0);
      check8("post_rst_data", data, 8'h00);

      // Good frames with 100 ns idle gaps.
      base = pulse_cnt;
      for (int i = 0; i < 5; i++) begin
         send_frame(good_b[i], good_p[i], 1'b1);
         expect_frame(good_b[i], $sformatf("good_%0d", i));
      end
      checkn("good_pulse_count", pulse_cnt - base, 5);

      // A5 has four ones, so odd parity needs 1; sending 0 makes it bad.
      base = pulse_cnt;
      send_frame(8'hA5, 1'b0, 1'b1);
      expect_none(8'hFF, "parity_err");
      checkn("parity_err_pulses", pulse_cnt - base, 0);
      send_frame(8'h3C, 1'b1, 1'b1);
      expect_frame(8'h3C, "after_parity");

      // Correct parity but stop bit 0.
      base = pulse_cnt;
      send_frame(8'h12, 1'b1, 1'b0);
      expect_none(8'h3C, "framing_err");
      checkn("framing_err_pulses", pulse_cnt - base, 0);
      @(negedge clk);
      ps2_data = 1'b1;
      send_frame(8'h34, 1'b0, 1'b1);
      expect_frame(8'h34, "after_framing");

      // Partial frame, stall past the timeout, then a full frame.
      base = pulse_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ps2_data = 1'b1;
      repeat (5100) @(negedge clk);
      checkn("timeout_no_pulse", pulse_cnt - base, 0);
      send_frame(8'hF0, 1'b1, 1'b1);
      expect_frame(8'hF0, "after_timeout");
      checkn("timeout_pulses", pulse_cnt - base, 1);

      // Back-to-back frames with no idle gap.
      base = pulse_cnt;
      send_frame(8'hC3, 1'b1, 1'b1);
      send_frame(8'h7E, 1'b1, 1'b1);
      expect_frame(8'h7E, "b2b_second");
      checkn("b2b_pulses", pulse_cnt - base, 2);
      if (rx_log.size() >= 2) check8("b2b_first", rx_log[rx_log.size() - 2], 8'hC3);
      else checkn("b2b_log_size", rx_log.size(), 2);

      // Reset after five data bits of 66 (LSB first: 0,1,1,0,0).
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check8("midrst_data", data, 8'h00);
      check1("midrst_valid", valid, 1'b0);
      repeat (3) @(negedge clk);
      ps2_data = 1'b1;
      reset    = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b1);
      expect_frame(8'h81, "after_midrst");

      repeat (4) @(negedge clk);
      checkn("double_pulses", dbl_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
